// File: rtl/img_sram_arbiter.sv
// Round-robin burst arbiter for the shared image SRAM port, with a mandatory turnaround cycle.
// Optional grant timeout when IMG_SRAM_ARB_TIMEOUT_EN is defined.
package img_sram_pkg;
  typedef struct packed {
    logic       sense_en;
    logic       write_en;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] din;
  } img_sram_ctrl_t;
endpackage

module img_sram_arbiter
  import img_sram_pkg::*;
#(
  parameter int unsigned NREQ = 3
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
  , parameter logic [15:0] MAX_HOLD = 16'd65535
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  img_sram_ctrl_t [NREQ-1:0]  req_ctrl,
  output logic [NREQ-1:0]            gnt,
  output img_sram_ctrl_t             sram_ctrl,
  input  logic [7:0]                 sram_dout,
  output logic [7:0]                 rd_data,
  output logic [NREQ-1:0]            rd_valid
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
  , output logic                     hold_viol
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rd_valid_q, rd_valid_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [IW-1:0]   winner;
  logic            owner_req;
  logic            pass;
  img_sram_ctrl_t  own_ctrl;

`ifdef IMG_SRAM_ARB_TIMEOUT_EN
  logic [15:0]     cnt_q, cnt_d;
  logic            viol_q, viol_d;
  logic [NREQ-1:0] blocked_q, blocked_d;

  // A revoked requester stays ineligible until it has dropped req once.
  assign elig      = req & ~blocked_q;
  assign hold_viol = viol_q;
`else
  assign elig = req;
`endif

  assign owner_req = req[owner_q];
  assign own_ctrl  = req_ctrl[owner_q];
  assign pass      = (state_q == GRANT) && owner_req;
  assign sram_ctrl = pass ? own_ctrl : '0;
  assign gnt       = gnt_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = sram_dout;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  always_comb begin
    rd_valid_d = '0;
    if (pass && own_ctrl.sense_en && !own_ctrl.write_en) rd_valid_d[owner_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    viol_d    = 1'b0;
    blocked_d = blocked_q & req;
`endif
    case (state_q)
      IDLE, TURN: begin
        gnt_d = '0;
        if (found) begin
          state_d        = GRANT;
          gnt_d[winner]  = 1'b1;
          owner_d        = winner;
          rr_ptr_d       = (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
          cnt_d          = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = TURN;
          gnt_d   = '0;
        end
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
        else if (cnt_q == MAX_HOLD - 16'd1) begin
          state_d            = TURN;
          gnt_d              = '0;
          viol_d             = 1'b1;
          blocked_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef IMG_SRAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      viol_q    <= 1'b0;
      blocked_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      viol_q    <= viol_d;
      blocked_q <= blocked_d;
    end
  end
`endif

endmodule

// File: tb/tb_img_sram_arbiter.sv
// Directed self-checking bench for img_sram_arbiter; covers the timeout path when
// IMG_SRAM_ARB_TIMEOUT_EN is defined.
module tb_img_sram_arbiter;
  import img_sram_pkg::*;

`ifdef IMG_SRAM_ARB_TIMEOUT_EN
  localparam int RX_LEN = 6;
`else
  localparam int RX_LEN = 10;
`endif

  logic                  clk;
  logic                  rst;
  logic [2:0]            req;
  img_sram_ctrl_t [2:0]  req_ctrl;
  logic [2:0]            gnt;
  img_sram_ctrl_t        sram_ctrl;
  logic [7:0]            sram_dout;
  logic [7:0]            rd_data;
  logic [2:0]            rd_valid;
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
  logic                  hold_viol;
`endif

  int vectors = 0;
  int miscompares = 0;

  img_sram_arbiter #(
    .NREQ(3)
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
    , .MAX_HOLD(16'd8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_ctrl(req_ctrl),
    .gnt(gnt),
    .sram_ctrl(sram_ctrl),
    .sram_dout(sram_dout),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
    , .hold_viol(hold_viol)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic img_sram_ctrl_t mk(input logic se, input logic we, input logic [7:0] r,
                                        input logic [7:0] c, input logic [7:0] d);
    img_sram_ctrl_t t;
    t.sense_en = se;
    t.write_en = we;
    t.row      = r;
    t.col      = c;
    t.din      = d;
    return t;
  endfunction

  initial begin
    img_sram_ctrl_t e;
    int order [4];
    order = '{0, 1, 2, 0};

    rst = 1'b1; req = '0; req_ctrl = '0; sram_dout = '0;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_sram_ctrl", 32'(sram_ctrl), 32'h0);
`ifdef IMG_SRAM_ARB_TIMEOUT_EN
    chk("reset_hold_viol", 32'(hold_viol), 32'h0);
`endif
    cyc(); cyc();
    rst = 1'b0;

    // rx write burst
    req = 3'b001;
    req_ctrl[0] = mk(1'b0, 1'b1, 8'd3, 8'd0, 8'h10);
    #1;
    chk("rx_idle_gnt", 32'(gnt), 32'h0);
    chk("rx_idle_ctrl", 32'(sram_ctrl), 32'h0);
    for (int i = 0; i < RX_LEN; i++) begin
      cyc();
      req_ctrl[0] = mk(1'b0, 1'b1, 8'd3, 8'(i), 8'(8'h10 + i));
      #1;
      chk("rx_gnt", 32'(gnt), 32'h1);
      chk("rx_write", 32'(sram_ctrl), 32'(mk(1'b0, 1'b1, 8'd3, 8'(i), 8'(8'h10 + i))));
    end
    cyc();
    req = 3'b000;
    #1;
    chk("rx_drop_gnt_still_high", 32'(gnt), 32'h1);
    chk("rx_drop_ctrl_masked", 32'(sram_ctrl), 32'h0);
    cyc();
    chk("rx_turn_gnt", 32'(gnt), 32'h0);
    chk("rx_turn_ctrl", 32'(sram_ctrl), 32'h0);
    cyc();

    // tx read, data returned the following cycle
    req = 3'b100;
    req_ctrl[2] = mk(1'b1, 1'b0, 8'd5, 8'd7, 8'h00);
    cyc();
    chk("tx_gnt", 32'(gnt), 32'h4);
    chk("tx_read_cmd", 32'(sram_ctrl), 32'(mk(1'b1, 1'b0, 8'd5, 8'd7, 8'h00)));
    chk("tx_rd_valid_before", 32'(rd_valid), 32'h0);
    cyc();
    req = 3'b000;
    sram_dout = 8'hA5;
    #1;
    chk("tx_rd_valid", 32'(rd_valid), 32'h4);
    chk("tx_rd_data", 32'(rd_data), 32'hA5);
    cyc();
    chk("tx_turn_rd_valid", 32'(rd_valid), 32'h0);
    chk("tx_turn_gnt", 32'(gnt), 32'h0);
    cyc();

    // all three requesting from reset
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) req_ctrl[i] = mk(1'b0, 1'b1, 8'(i), 8'(8'h20 + i), 8'(8'h30 + i));
    req = 3'b111;
    for (int b = 0; b < 4; b++) begin
      cyc();
      e = mk(1'b0, 1'b1, 8'(order[b]), 8'(8'h20 + order[b]), 8'(8'h30 + order[b]));
      chk("rr_gnt", 32'(gnt), 32'(3'b001 << order[b]));
      chk("rr_ctrl", 32'(sram_ctrl), 32'(e));
      cyc();
      chk("rr_gnt_hold", 32'(gnt), 32'(3'b001 << order[b]));
      cyc();
      req[order[b]] = 1'b0;
      #1;
      chk("rr_drop_gnt", 32'(gnt), 32'(3'b001 << order[b]));
      chk("rr_drop_ctrl", 32'(sram_ctrl), 32'h0);
      cyc();
      chk("rr_turn_gnt", 32'(gnt), 32'h0);
      req[order[b]] = 1'b1;
    end
    req = 3'b000;
    cyc(); cyc();

    // reset in the middle of a conv read burst
    req = 3'b010;
    for (int c = 0; c <= 4; c++) begin
      req_ctrl[1] = mk(1'b1, 1'b0, 8'd2, 8'(c), 8'h00);
      cyc();
      req_ctrl[1] = mk(1'b1, 1'b0, 8'd2, 8'(c), 8'h00);
      #1;
      chk("conv_gnt", 32'(gnt), 32'h2);
    end
    chk("conv_rd_valid_pending", 32'(rd_valid), 32'h2);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_ctrl", 32'(sram_ctrl), 32'h0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("postrst_gnt_low", 32'(gnt), 32'h0);
    cyc();
    chk("postrst_gnt1", 32'(gnt), 32'h2);
    req = 3'b000;
    cyc(); cyc();
    // rr_ptr was left at 2 by the conv grant
    req = 3'b101;
    req_ctrl[0] = '0; req_ctrl[2] = '0;
    cyc();
    chk("postrst_rr_ptr", 32'(gnt), 32'h4);
    req = 3'b000;
    cyc(); cyc();

`ifdef IMG_SRAM_ARB_TIMEOUT_EN
    req = 3'b100;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("to_gnt", 32'(gnt), 32'h4);
      chk("to_no_viol", 32'(hold_viol), 32'h0);
    end
    req = 3'b101;
    cyc();
    chk("to_revoked_gnt", 32'(gnt), 32'h0);
    chk("to_viol", 32'(hold_viol), 32'h1);
    cyc();
    chk("to_next_gnt", 32'(gnt), 32'h1);
    chk("to_viol_pulse", 32'(hold_viol), 32'h0);
    req = 3'b000;
    cyc(); cyc();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "bench did not complete");
  end
endmodule
